rob_commit: RTL

- Circular reorder buffer directly downstream of the write-back stage.
- Allocates one entry per dispatched instruction, in program order.
- Absorbs write-back results (tag, value), which may arrive out of order.
- Retires at most one entry per cycle, strictly in order, to the architectural register file. This makes retirement of the values the write-back stage marks ready-to-retire an explicit, cycle-accurate stage.

---
 rtl/rob_pkg.sv | 16 +
 rtl/rob_commit_if.sv | 32 +++
 rtl/rob_ptr.sv | 34 +++
 rtl/rob_commit.sv | 96 +++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared constants and entry types for the reorder buffer
package rob_pkg;
   localparam int ROB_DEPTH = 8;
   localparam int TAG_W     = $clog2(ROB_DEPTH);
   localparam int DATA_W    = 32;
   localparam int REG_W     = 5;

   typedef logic [TAG_W-1:0] rob_tag_t;

   typedef struct packed {
      logic              busy;
      logic              ready;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] value;
   } rob_entry_t;
endpackage

// File: rtl/rob_commit_if.sv
// rtl/rob_commit_if.sv - dispatch, write-back, commit and status signals of the reorder buffer
interface rob_commit_if
   import rob_pkg::*;
();
   logic              alloc_valid;
   logic [REG_W-1:0]  alloc_dest;
   logic              alloc_ready;
   rob_tag_t          alloc_tag;
   logic              wb_valid;
   rob_tag_t          wb_tag;
   logic [DATA_W-1:0] wb_value;
   logic              commit_valid;
   logic [REG_W-1:0]  commit_reg;
   logic [DATA_W-1:0] commit_value;
   rob_tag_t          commit_tag;
   logic [TAG_W:0]    rob_count;
   logic              rob_full;
   logic              rob_empty;
   logic              wb_err;

   modport master (
      output alloc_valid, alloc_dest, wb_valid, wb_tag, wb_value,
      input  alloc_ready, alloc_tag, commit_valid, commit_reg, commit_value,
             commit_tag, rob_count, rob_full, rob_empty, wb_err
   );

   modport slave (
      input  alloc_valid, alloc_dest, wb_valid, wb_tag, wb_value,
      output alloc_ready, alloc_tag, commit_valid, commit_reg, commit_value,
             commit_tag, rob_count, rob_full, rob_empty, wb_err
   );
endinterface

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - head/tail pointers and occupancy count of the reorder buffer
module rob_ptr
   import rob_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           inc_head,
   input  logic           inc_tail,
   output rob_tag_t       head,
   output rob_tag_t       tail,
   output logic [TAG_W:0] count,
   output logic           full,
   output logic           empty
);
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head <= head + rob_tag_t'(inc_head);
         tail <= tail + rob_tag_t'(inc_tail);
         // Simultaneous allocate and retire leaves occupancy unchanged.
         case ({inc_tail, inc_head})
            2'b10:   count <= count + (TAG_W+1)'(1);
            2'b01:   count <= count - (TAG_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == (TAG_W+1)'(ROB_DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order retirement reorder buffer; ROB_WB_BYPASS_EN lets a head write-back retire in the same edge
module rob_commit
   import rob_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   rob_commit_if.slave  bus
);
   rob_entry_t        entries [ROB_DEPTH];
   rob_tag_t          head;
   rob_tag_t          tail;
   logic [TAG_W:0]    count;
   logic              full;
   logic              empty;
   logic              alloc_fire;
   logic              wb_ok;
   logic              head_ready;
   logic              commit_fire;
   logic [DATA_W-1:0] commit_data;

   rob_ptr u_ptr (
      .clk      (clk),
      .rst      (rst),
      .inc_head (commit_fire),
      .inc_tail (alloc_fire),
      .head     (head),
      .tail     (tail),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign alloc_fire = bus.alloc_valid && !full;
   // An entry allocated this cycle is not yet busy, so a same-cycle write-back to it is rejected.
   assign wb_ok      = bus.wb_valid && entries[bus.wb_tag].busy && !entries[bus.wb_tag].ready;
   assign head_ready = entries[head].busy && entries[head].ready;

`ifdef ROB_WB_BYPASS_EN
   // Head ready and head bypass are exclusive: the bypass needs the head not yet ready.
   assign commit_fire = head_ready || (wb_ok && (bus.wb_tag == head));
   assign commit_data = head_ready ? entries[head].value : bus.wb_value;
`else
   assign commit_fire = head_ready;
   assign commit_data = entries[head].value;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            entries[i].busy  <= 1'b0;
            entries[i].ready <= 1'b0;
         end
      end else begin
         if (wb_ok) begin
            entries[bus.wb_tag].value <= bus.wb_value;
            entries[bus.wb_tag].ready <= 1'b1;
         end
         // Later assignment wins, so a bypassed head is freed rather than marked ready.
         if (commit_fire) begin
            entries[head].busy  <= 1'b0;
            entries[head].ready <= 1'b0;
         end
         if (alloc_fire) begin
            entries[tail].busy  <= 1'b1;
            entries[tail].ready <= 1'b0;
            entries[tail].dest  <= bus.alloc_dest;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.commit_valid <= 1'b0;
         bus.commit_reg   <= '0;
         bus.commit_value <= '0;
         bus.commit_tag   <= '0;
         bus.wb_err       <= 1'b0;
      end else begin
         bus.commit_valid <= commit_fire;
         if (commit_fire) begin
            bus.commit_reg   <= entries[head].dest;
            bus.commit_value <= commit_data;
            bus.commit_tag   <= head;
         end
         if (bus.wb_valid && !wb_ok) begin
            bus.wb_err <= 1'b1;
         end
      end
   end

   assign bus.alloc_ready = !full;
   assign bus.alloc_tag   = tail;
   assign bus.rob_count   = count;
   assign bus.rob_full    = full;
   assign bus.rob_empty   = empty;
endmodule
